calc_feeder: RTL and testbench
==============================

CALC_FEEDER -- requirements
Module: calc_feeder

Interface
REQ-001 Parameter: DEPTH, 4, expression FIFO entries (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high; same net drives the downstream calc stage's rst.
REQ-004 inValid  input  1  upstream offers an expression this cycle.
REQ-005 inReady  output  1  feeder can accept; equals !full, combinational from FIFO count.
REQ-006 inNum1  input  8  first operand.
REQ-007 inOp  input  3  operator: 0 add, 1 sub, 2 mul, 3 square num1, 4-7 illegal.
REQ-008 inNum2  input  8  second operand (ignored by calc for op 3, still issued).
REQ-009 calcValid  output  1  registered beat-valid to calc.
REQ-010 calcData  output  8  registered beat data to calc.
REQ-011 calcOut  input  8  calc result register.
REQ-012 resValid  output  1  registered one-cycle result pulse.
REQ-013 resData  output  8  registered result, held until next pulse.
REQ-014 resErr  output  1  registered; 1 with resValid when op was illegal.
REQ-015 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-016 FIFO accepts {inNum1,inOp,inNum2} on posedge when inValid && inReady; order strictly preserved.
REQ-017 No fall-through: entry pushed at edge E is poppable no earlier than edge E+1.
REQ-018 Push and pop on same edge both occur; count unchanged; full blocks push via inReady=0, no overflow, no underflow.
REQ-019 FSM states: IDLE, ISSUE_A, ISSUE_OP, ISSUE_B, CAPTURE; name = what is on calc bus during that cycle.
REQ-020 IDLE: FIFO empty -> stay, calcValid=0.
REQ-021 IDLE, FIFO non-empty, op<=3: pop; next state ISSUE_A with calcValid=1, calcData=num1.
REQ-022 IDLE, FIFO non-empty, op>=4: pop; no calc beats; next cycle resValid=1, resErr=1, resData=0; stay IDLE.
REQ-023 ISSUE_A -> ISSUE_OP: calcValid=1, calcData={5'b0,op}.
REQ-024 ISSUE_OP -> ISSUE_B: calcValid=1, calcData=num2.
REQ-025 ISSUE_B -> CAPTURE: calcValid=0, calcData=0; calc's result lands on calcOut at this edge.
REQ-026 CAPTURE: sample calcOut; next cycle resValid=1, resErr=0, resData=calcOut; next state IDLE, or ISSUE_A directly (pop in same edge) if FIFO non-empty with legal op.
REQ-027 Latency: pop edge E0 -> resValid high in cycle after E4; sustained throughput one legal expression per 4 cycles.
REQ-028 Arithmetic is calc's, modulo 256 (e.g. 200-100=100, 16*16=0, 3-5=254); feeder never alters calcOut.
REQ-029 calcValid never asserted outside ISSUE_A/ISSUE_OP/ISSUE_B; exactly three beats per legal expression, keeping calc's 3-state sequence aligned.
REQ-030 resValid is a single-cycle pulse; resData/resErr hold between pulses.

Reset
REQ-031 rst=1 at posedge: FSM=IDLE, FIFO emptied (count=0), calcValid=0, calcData=0, resValid=0, resData=0, resErr=0; in-flight expression discarded, no result.
REQ-032 rst has priority over push, pop and all FSM transitions; inReady=1 in cycle after reset release.

Verification
REQ-033 Reset, push (5,0,3) -> calcData beats 5,0,3 on consecutive cycles, resData=8, resErr=0, resValid 4 cycles after pop.
REQ-034 Push (200,1,100), (16,2,16), (3,1,5) -> results 100, 0, 254 in order, 4 cycles apart.
REQ-035 Push (12,3,99) -> beats 12,3,99, resData=144.
REQ-036 Hold inValid with 6 distinct entries, DEPTH=4 -> inReady drops at count=4, no loss/duplication, results in push order.
REQ-037 Push (7,5,7) then (1,0,1) -> first: resErr=1, resData=0, no calcValid; second: resData=2, resErr=0.
REQ-038 Assert rst during ISSUE_OP with 2 queued -> next cycle all outputs 0, count=0; new push (2,2,3) -> resData=6.

Source files
------------

// File: rtl/calc_feeder_if.sv
// Bundle of the feeder's upstream handshake, calc-stage bus and result outputs.
// The feeder uses the slave view; its environment uses the master view.
interface calc_feeder_if #(
  parameter int DEPTH = 4
);
  logic                   inValid;
  logic                   inReady;
  logic [7:0]             inNum1;
  logic [2:0]             inOp;
  logic [7:0]             inNum2;
  logic                   calcValid;
  logic [7:0]             calcData;
  logic [7:0]             calcOut;
  logic                   resValid;
  logic [7:0]             resData;
  logic                   resErr;
  logic [$clog2(DEPTH):0] count;

  modport slave (
    input  inValid, inNum1, inOp, inNum2, calcOut,
    output inReady, calcValid, calcData, resValid, resData, resErr, count
  );

  modport master (
    output inValid, inNum1, inOp, inNum2, calcOut,
    input  inReady, calcValid, calcData, resValid, resData, resErr, count
  );
endinterface

// File: rtl/calc_feeder.sv
// Queues {num1, op, num2} expressions and serialises each legal one into three
// beats for the downstream calc stage, then reports the calc result.
module calc_feeder #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  calc_feeder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_A,
    ISSUE_OP,
    ISSUE_B,
    CAPTURE
  } state_t;

  // ---------------- expression FIFO ----------------
  logic [18:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [18:0]   head;
  logic [7:0]    head_num1;
  logic [2:0]    head_op;
  logic [7:0]    head_num2;
  logic          head_legal;

  assign full       = (count_reg == FULL_COUNT);
  assign empty      = (count_reg == '0);
  assign push       = bus.inValid && !full;
  assign head       = mem[rd_ptr_reg];
  assign head_num1  = head[18:11];
  assign head_op    = head[10:8];
  assign head_num2  = head[7:0];
  assign head_legal = !head_op[2];

  assign bus.inReady = !full;
  assign bus.count   = count_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == AW'(gi))) begin
          mem[gi] <= {bus.inNum1, bus.inOp, bus.inNum2};
        end
      end
    end
  endgenerate

  // pop is only ever requested by the FSM when the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- sequencing FSM ----------------
  state_t     state_reg, state_next;
  logic [2:0] op_reg, op_next;
  logic [7:0] num2_reg, num2_next;
  logic       calc_valid_reg, calc_valid_next;
  logic [7:0] calc_data_reg, calc_data_next;
  logic       res_valid_reg, res_valid_next;
  logic [7:0] res_data_reg, res_data_next;
  logic       res_err_reg, res_err_next;

  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    num2_next       = num2_reg;
    pop             = 1'b0;
    calc_valid_next = 1'b0;
    calc_data_next  = 8'd0;
    res_valid_next  = 1'b0;
    res_data_next   = res_data_reg;
    res_err_next    = res_err_reg;

    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_legal) begin
            state_next      = ISSUE_A;
            op_next         = head_op;
            num2_next       = head_num2;
            calc_valid_next = 1'b1;
            calc_data_next  = head_num1;
          end else begin
            // illegal op never touches calc, so its sequence stays aligned
            res_valid_next = 1'b1;
            res_data_next  = 8'd0;
            res_err_next   = 1'b1;
          end
        end
      end
      ISSUE_A: begin
        state_next      = ISSUE_OP;
        calc_valid_next = 1'b1;
        calc_data_next  = {5'b0, op_reg};
      end
      ISSUE_OP: begin
        state_next      = ISSUE_B;
        calc_valid_next = 1'b1;
        calc_data_next  = num2_reg;
      end
      ISSUE_B: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        res_valid_next = 1'b1;
        res_data_next  = bus.calcOut;
        res_err_next   = 1'b0;
        // an illegal head waits for IDLE so its pulse cannot collide with this one
        if (!empty && head_legal) begin
          pop             = 1'b1;
          state_next      = ISSUE_A;
          op_next         = head_op;
          num2_next       = head_num2;
          calc_valid_next = 1'b1;
          calc_data_next  = head_num1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      op_reg         <= 3'd0;
      num2_reg       <= 8'd0;
      calc_valid_reg <= 1'b0;
      calc_data_reg  <= 8'd0;
      res_valid_reg  <= 1'b0;
      res_data_reg   <= 8'd0;
      res_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      num2_reg       <= num2_next;
      calc_valid_reg <= calc_valid_next;
      calc_data_reg  <= calc_data_next;
      res_valid_reg  <= res_valid_next;
      res_data_reg   <= res_data_next;
      res_err_reg    <= res_err_next;
    end
  end

  assign bus.calcValid = calc_valid_reg;
  assign bus.calcData  = calc_data_reg;
  assign bus.resValid  = res_valid_reg;
  assign bus.resData   = res_data_reg;
  assign bus.resErr    = res_err_reg;
endmodule

// File: tb/tb_calc_feeder.sv
// Scoreboard bench for calc_feeder with a behavioural three-beat calc stage.
module tb_calc_feeder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_feeder_if #(.DEPTH(DEPTH)) bus ();

  calc_feeder #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // behavioural calc stage: beats num1, op, num2; result registered on the num2 beat
  logic [1:0] cseq;
  logic [7:0] ca;
  logic [2:0] cop;
  logic [7:0] calc_out;
  assign bus.calcOut = calc_out;

  function automatic logic [7:0] calc_fn(input logic [7:0] a, input logic [2:0] o,
                                         input logic [7:0] b);
    logic [15:0] p;
    case (o)
      3'd0:    p = {8'd0, a} + {8'd0, b};
      3'd1:    p = {8'd0, a} - {8'd0, b};
      3'd2:    p = a * b;
      3'd3:    p = a * a;
      default: p = 16'd0;
    endcase
    return p[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cseq     <= 2'd0;
      ca       <= 8'd0;
      cop      <= 3'd0;
      calc_out <= 8'd0;
    end else if (bus.calcValid) begin
      case (cseq)
        2'd0: begin ca <= bus.calcData; cseq <= 2'd1; end
        2'd1: begin cop <= bus.calcData[2:0]; cseq <= 2'd2; end
        default: begin calc_out <= calc_fn(ca, cop, bus.calcData); cseq <= 2'd0; end
      endcase
    end
  end

  // scoreboard state
  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } res_t;

  res_t       exp_res[$];
  logic [7:0] exp_beats[$];
  int         a_cycs[$];
  int         res_cycs[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  bit         mon_en   = 1'b0;
  bit         saw_full = 1'b0;
  bit         have_last = 1'b0;
  logic [7:0] last_data;
  logic       last_err;
  int         beat_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // monitor: compares DUT activity with the scoreboard queues
  always @(negedge clk) begin
    if (rst) begin
      beat_idx  = 0;
      have_last = 1'b0;
    end else if (mon_en) begin
      if (bus.calcValid) begin
        if (exp_beats.size() == 0) fail_now("unexpected_calc_beat");
        else chk("calc_beat", int'(bus.calcData), int'(exp_beats.pop_front()));
        if (beat_idx == 0) a_cycs.push_back(cyc);
        beat_idx = (beat_idx == 2) ? 0 : beat_idx + 1;
      end
      if (bus.count == 3'(DEPTH)) begin
        saw_full = 1'b1;
        chk("ready_when_full", int'(bus.inReady), 0);
      end
      if (bus.resValid) begin
        if (exp_res.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          res_t e;
          e = exp_res.pop_front();
          chk("res_data", int'(bus.resData), int'(e.data));
          chk("res_err", int'(bus.resErr), int'(e.err));
          if (!e.err) begin
            if (a_cycs.size() == 0) fail_now("result_without_beats");
            else chk("latency", cyc - a_cycs.pop_front(), 4);
          end
        end
        res_cycs.push_back(cyc);
        last_data = bus.resData;
        last_err  = bus.resErr;
        have_last = 1'b1;
      end else if (have_last) begin
        chk("res_data_hold", int'(bus.resData), int'(last_data));
        chk("res_err_hold", int'(bus.resErr), int'(last_err));
      end
    end
  end

  // offers one expression, returns #1 after the accepting edge with inValid still high
  task automatic push(input logic [7:0] a, input logic [2:0] o, input logic [7:0] b,
                      input logic [7:0] exp_data, input bit track);
    bit acc;
    int waited;
    res_t e;
    bus.inValid = 1'b1;
    bus.inNum1  = a;
    bus.inOp    = o;
    bus.inNum2  = b;
    if (track) begin
      e.data = exp_data;
      e.err  = o[2];
      exp_res.push_back(e);
      if (!o[2]) begin
        exp_beats.push_back(a);
        exp_beats.push_back({5'b0, o});
        exp_beats.push_back(b);
      end
    end
    acc    = 1'b0;
    waited = 0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.inReady;
      @(posedge clk);
      #1;
      waited++;
      if (!acc && waited > 200) begin
        fail_now("push_timeout");
        break;
      end
    end
  endtask

  task automatic idle_in();
    bus.inValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_res.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_res.size() != 0) fail_now("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_calcValid"}, int'(bus.calcValid), 0);
    chk({tag, "_calcData"}, int'(bus.calcData), 0);
    chk({tag, "_resValid"}, int'(bus.resValid), 0);
    chk({tag, "_resData"}, int'(bus.resData), 0);
    chk({tag, "_resErr"}, int'(bus.resErr), 0);
    chk({tag, "_count"}, int'(bus.count), 0);
    chk({tag, "_inReady"}, int'(bus.inReady), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.inValid = 1'b0;
    bus.inNum1  = 8'd0;
    bus.inOp    = 3'd0;
    bus.inNum2  = 8'd0;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // single add 5+3
    push(8'd5, 3'd0, 8'd3, 8'd8, 1'b1);
    idle_in();
    drain();
    $display("txn add: 5+3 expected 8");

    // modulo-256 arithmetic, back-to-back throughput
    res_cycs.delete();
    push(8'd200, 3'd1, 8'd100, 8'd100, 1'b1);
    push(8'd16, 3'd2, 8'd16, 8'd0, 1'b1);
    push(8'd3, 3'd1, 8'd5, 8'd254, 1'b1);
    idle_in();
    drain();
    if (res_cycs.size() == 3) begin
      chk("throughput_1", res_cycs[1] - res_cycs[0], 4);
      chk("throughput_2", res_cycs[2] - res_cycs[1], 4);
    end else begin
      fail_now("throughput_result_count");
    end
    $display("txn modulo: 200-100, 16*16, 3-5");

    // square of num1, num2 still issued
    push(8'd12, 3'd3, 8'd99, 8'd144, 1'b1);
    idle_in();
    drain();
    $display("txn square: 12^2 expected 144");

    // FIFO fill with continuous inValid
    saw_full = 1'b0;
    push(8'd1, 3'd0, 8'd2, 8'd3, 1'b1);
    push(8'd10, 3'd1, 8'd3, 8'd7, 1'b1);
    push(8'd4, 3'd2, 8'd5, 8'd20, 1'b1);
    push(8'd9, 3'd3, 8'd0, 8'd81, 1'b1);
    push(8'd100, 3'd0, 8'd100, 8'd200, 1'b1);
    push(8'd50, 3'd1, 8'd60, 8'd246, 1'b1);
    idle_in();
    drain();
    chk("fifo_reached_full", int'(saw_full), 1);
    $display("txn fill: six entries through DEPTH=%0d FIFO", DEPTH);

    // illegal op then legal
    push(8'd7, 3'd5, 8'd7, 8'd0, 1'b1);
    push(8'd1, 3'd0, 8'd1, 8'd2, 1'b1);
    idle_in();
    drain();
    $display("txn illegal: op 5 flagged, then 1+1");

    // reset while ISSUE_OP is on the bus with two entries queued
    mon_en = 1'b0;
    push(8'd1, 3'd0, 8'd1, 8'd0, 1'b0);
    push(8'd2, 3'd0, 8'd2, 8'd0, 1'b0);
    push(8'd3, 3'd0, 8'd3, 8'd0, 1'b0);
    idle_in();
    chk("pre_rst_queued", int'(bus.count), 2);
    chk("pre_rst_op_beat_valid", int'(bus.calcValid), 1);
    chk("pre_rst_op_beat_data", int'(bus.calcData), 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("midrst");
    exp_res.delete();
    exp_beats.delete();
    a_cycs.delete();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    push(8'd2, 3'd2, 8'd3, 8'd6, 1'b1);
    idle_in();
    drain();
    $display("txn reset_recovery: 2*3 expected 6");

    chk("leftover_results", exp_res.size(), 0);
    chk("leftover_beats", exp_beats.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
